// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file write-back path.
package rf_wb_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << a;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests; head is visible the cycle after a push.
// Pushes at full and pops at empty are ignored.
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  wb_req_t                req_i,
  input  logic                   pop_i,
  output wb_req_t                head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Depth is a power of two, so natural pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= req_i;
  end

endmodule

// File: rtl/rf_writeback.sv
// Merges W-stage and buffered MDU results into one registered register-file write per cycle,
// tracking outstanding MDU destinations in a pending scoreboard; pipe writes always win.
module rf_writeback #(
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pipe_valid,
  input  logic [ADDR_W-1:0]           pipe_addr,
  input  logic [DATA_W-1:0]           pipe_data,
  input  logic                        issue_valid,
  input  logic [ADDR_W-1:0]           issue_addr,
  input  logic                        mdu_valid,
  output logic                        mdu_ready,
  input  logic [ADDR_W-1:0]           mdu_addr,
  input  logic [DATA_W-1:0]           mdu_data,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_a3,
  output logic [DATA_W-1:0]           rf_dw,
  output logic [31:0]                 pending,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        err
);

  import rf_wb_pkg::*;

  wb_req_t push_req, head_req;
  logic    fifo_full, fifo_empty;
  logic    push, pop;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_vld;

  logic              rf_we_q,     rf_we_d;
  logic [ADDR_W-1:0] rf_a3_q,     rf_a3_d;
  logic [DATA_W-1:0] rf_dw_q,     rf_dw_d;
  logic              from_fifo_q, from_fifo_d;
  logic [31:0]       pending_q,   pending_d;
  logic              err_q,       err_d;
  logic [31:0]       set_mask,    clr_mask;
  logic              viol;

  assign push_req.addr = mdu_addr;
  assign push_req.data = mdu_data;

  assign mdu_ready = !fifo_full;
  assign push      = mdu_valid && mdu_ready;
  assign pop       = !pipe_valid && !fifo_empty;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .req_i   (push_req),
    .pop_i   (pop),
    .head_o  (head_req),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    sel_vld  = pipe_valid || !fifo_empty;
    sel_addr = pipe_valid ? pipe_addr : head_req.addr;
    sel_data = pipe_valid ? pipe_data : head_req.data;

    // Register 0 entries are consumed but never reach the register file.
    rf_we_d     = sel_vld && (sel_addr != REG_ZERO);
    rf_a3_d     = rf_we_d ? sel_addr : rf_a3_q;
    rf_dw_d     = rf_we_d ? sel_data : rf_dw_q;
    from_fifo_d = rf_we_d && !pipe_valid;

    // A bit clears only once its MDU write has actually been presented; a same-edge issue re-sets it.
    clr_mask  = (rf_we_q && from_fifo_q) ? reg_onehot(rf_a3_q) : '0;
    set_mask  = (issue_valid && (issue_addr != REG_ZERO)) ? reg_onehot(issue_addr) : '0;
    pending_d = (pending_q & ~clr_mask) | set_mask;

    viol  = (issue_valid && pending_q[issue_addr])
          | (pipe_valid  && pending_q[pipe_addr])
          | (mdu_valid   && !pending_q[mdu_addr]);
    err_d = err_q | viol;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_q     <= 1'b0;
      rf_a3_q     <= '0;
      rf_dw_q     <= '0;
      from_fifo_q <= 1'b0;
      pending_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      rf_we_q     <= rf_we_d;
      rf_a3_q     <= rf_a3_d;
      rf_dw_q     <= rf_dw_d;
      from_fifo_q <= from_fifo_d;
      pending_q   <= pending_d;
      err_q       <= err_d;
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_a3   = rf_a3_q;
  assign rf_dw   = rf_dw_q;
  assign pending = pending_q;
  assign err     = err_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: expected register-file writes are queued at stimulus time
// and popped by a negedge monitor; state outputs are checked directly after each edge.
module tb_rf_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_dw;
  logic [31:0] pending;
  logic [1:0]  fifo_count;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] exp_q[$];
  logic [36:0] exp_w;

  always #5 clk = ~clk;

  rf_writeback #(
    .FIFO_DEPTH (2),
    .DATA_W     (32),
    .ADDR_W     (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pipe_valid  (pipe_valid),
    .pipe_addr   (pipe_addr),
    .pipe_data   (pipe_data),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .mdu_valid   (mdu_valid),
    .mdu_ready   (mdu_ready),
    .mdu_addr    (mdu_addr),
    .mdu_data    (mdu_data),
    .rf_we       (rf_we),
    .rf_a3       (rf_a3),
    .rf_dw       (rf_dw),
    .pending     (pending),
    .fifo_count  (fifo_count),
    .err         (err)
  );

  // Write monitor: every rf_we cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got a3=%0d dw=%h, required no write", rf_a3, rf_dw);
      end else begin
        exp_w = exp_q.pop_front();
        if ({rf_a3, rf_dw} !== exp_w) begin
          n_fail++;
          $display("FAIL write_order: got a3=%0d dw=%h, required a3=%0d dw=%h",
                   rf_a3, rf_dw, exp_w[36:32], exp_w[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_valid  = 1'b0;
    issue_valid = 1'b0;
    mdu_valid   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    idle();
    #1;
    chk("rst_we",      64'(rf_we),      64'd0);
    chk("rst_pending", 64'(pending),    64'd0);
    chk("rst_count",   64'(fifo_count), 64'd0);
    chk("rst_err",     64'(err),        64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  logic [4:0] mq [3];
  logic [4:0] pa [4];
  int         idx;
  logic       acc;

  initial begin
    reset = 1'b0;
    idle();
    pipe_addr = '0; pipe_data = '0; issue_addr = '0; mdu_addr = '0; mdu_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_we",      64'(rf_we),      64'd0);
    chk("init_a3",      64'(rf_a3),      64'd0);
    chk("init_dw",      64'(rf_dw),      64'd0);
    chk("init_pending", 64'(pending),    64'd0);
    chk("init_count",   64'(fifo_count), 64'd0);
    chk("init_err",     64'(err),        64'd0);
    reset = 1'b1;
    #1;
    chk("init_ready",   64'(mdu_ready),  64'd1);

    // Pipe write lands one cycle later.
    pipe_valid = 1'b1; pipe_addr = 5'd5; pipe_data = 32'h1234;
    exp_q.push_back({5'd5, 32'h1234});
    cyc(); idle();
    chk("pipe_we",      64'(rf_we),   64'd1);
    chk("pipe_pending", 64'(pending), 64'd0);
    chk("pipe_err",     64'(err),     64'd0);

    // Single MDU op: issue, result 4 cycles later, write two cycles after acceptance.
    issue_valid = 1'b1; issue_addr = 5'd7;
    cyc(); idle();
    chk("issue_pending", 64'(pending), 64'h80);
    repeat (3) cyc();
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'hDEADBEEF;
    exp_q.push_back({5'd7, 32'hDEADBEEF});
    cyc(); idle();
    chk("mdu_head_count", 64'(fifo_count), 64'd1);
    chk("mdu_pend_n1",    64'(pending[7]), 64'd1);
    cyc();
    chk("mdu_we_n2",      64'(rf_we),      64'd1);
    chk("mdu_a3_n2",      64'(rf_a3),      64'd7);
    chk("mdu_pend_n2",    64'(pending[7]), 64'd1);
    cyc();
    chk("mdu_pend_n3",    64'(pending[7]), 64'd0);
    chk("mdu_we_n3",      64'(rf_we),      64'd0);

    // Backpressure: three MDU results while the pipe owns the write port for 4 cycles.
    issue_valid = 1'b1; issue_addr = 5'd3; cyc();
    issue_addr = 5'd4; cyc();
    issue_addr = 5'd6; cyc();
    idle();
    chk("bp_pending", 64'(pending), 64'h58);
    mq[0] = 5'd3;  mq[1] = 5'd4;  mq[2] = 5'd6;
    pa[0] = 5'd10; pa[1] = 5'd11; pa[2] = 5'd13; pa[3] = 5'd14;
    idx = 0;
    for (int i = 0; i < 12 && (idx < 3 || i < 5); i++) begin
      pipe_valid = (i < 4);
      if (i < 4) begin
        pipe_addr = pa[i];
        pipe_data = 32'hA000 + 32'(i);
        exp_q.push_back({pa[i], 32'hA000 + 32'(i)});
      end
      if (i == 4) begin
        for (int k = 0; k < 3; k++) exp_q.push_back({mq[k], 32'hB000 + 32'(k)});
      end
      mdu_valid = (idx < 3);
      if (idx < 3) begin
        mdu_addr = mq[idx];
        mdu_data = 32'hB000 + 32'(idx);
      end
      if (i == 2) chk("bp_ready_full",     64'(mdu_ready), 64'd0);
      if (i == 4) chk("bp_ready_full_pop", 64'(mdu_ready), 64'd0);
      acc = mdu_valid && mdu_ready;
      cyc();
      if (acc) idx++;
    end
    idle();
    chk("bp_accepted", 64'(idx), 64'd3);
    repeat (4) cyc();
    chk("bp_count_drained", 64'(fifo_count), 64'd0);
    chk("bp_pending_clear", 64'(pending),    64'd0);
    chk("bp_err",           64'(err),        64'd0);

    // Issue to an already-pending register.
    issue_valid = 1'b1; issue_addr = 5'd9;
    cyc();
    chk("v1_err_before", 64'(err), 64'd0);
    cyc(); idle();
    chk("v1_err", 64'(err), 64'd1);
    repeat (2) cyc();
    chk("v1_sticky", 64'(err), 64'd1);
    do_reset();

    // Pipe write to a pending register.
    issue_valid = 1'b1; issue_addr = 5'd9;
    cyc(); idle();
    chk("v2_err_before", 64'(err), 64'd0);
    pipe_valid = 1'b1; pipe_addr = 5'd9; pipe_data = 32'h9999;
    exp_q.push_back({5'd9, 32'h9999});
    cyc(); idle();
    chk("v2_err", 64'(err), 64'd1);
    do_reset();

    // MDU result to a register nobody issued.
    mdu_valid = 1'b1; mdu_addr = 5'd12; mdu_data = 32'hC0C0;
    exp_q.push_back({5'd12, 32'hC0C0});
    cyc(); idle();
    chk("v3_err", 64'(err), 64'd1);
    repeat (3) cyc();
    chk("v3_sticky", 64'(err), 64'd1);

    // Register 0: pipe and MDU writes are swallowed, issue sets nothing.
    pipe_valid = 1'b1; pipe_addr = 5'd0; pipe_data = 32'h55;
    issue_valid = 1'b1; issue_addr = 5'd0;
    cyc(); idle();
    chk("r0_pipe_we",  64'(rf_we),   64'd0);
    chk("r0_pending",  64'(pending), 64'd0);
    mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'h66;
    cyc(); idle();
    chk("r0_mdu_count", 64'(fifo_count), 64'd1);
    cyc();
    chk("r0_mdu_pop",   64'(fifo_count), 64'd0);
    cyc();
    chk("r0_mdu_we",    64'(rf_we),      64'd0);

    // Reset while the FIFO holds two results and pending=0x180.
    issue_valid = 1'b1; issue_addr = 5'd7; cyc();
    issue_addr = 5'd8; cyc();
    idle();
    pipe_valid = 1'b1; pipe_addr = 5'd1; pipe_data = 32'h11;
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'h77;
    exp_q.push_back({5'd1, 32'h11});
    cyc();
    pipe_addr = 5'd2; pipe_data = 32'h22;
    mdu_addr = 5'd8; mdu_data = 32'h88;
    exp_q.push_back({5'd2, 32'h22});
    cyc();
    mdu_valid = 1'b0;
    pipe_addr = 5'd1; pipe_data = 32'hEE;
    chk("mr_count_full", 64'(fifo_count), 64'd2);
    chk("mr_pending",    64'(pending),    64'h180);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mr_count", 64'(fifo_count), 64'd0);
    chk("mr_pend",  64'(pending),    64'd0);
    chk("mr_we",    64'(rf_we),      64'd0);
    idle();
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("mr_ready", 64'(mdu_ready), 64'd1);
    repeat (6) cyc();
    chk("mr_after_count",   64'(fifo_count), 64'd0);
    chk("mr_after_pending", 64'(pending),    64'd0);

    repeat (2) cyc();
    chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
